// File: rtl/d_phy_pkg.sv
// Shared constants for the D-PHY lane: FSM state codes, sync byte, LP line codes.
package d_phy_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LP01    = 3'd1;
  localparam state_t ST_LP00    = 3'd2;
  localparam state_t ST_HS_ZERO = 3'd3;
  localparam state_t ST_SYNC    = 3'd4;
  localparam state_t ST_DATA    = 3'd5;
  localparam state_t ST_TRAIL   = 3'd6;
  localparam state_t ST_POST    = 3'd7;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP line codes packed as {lp_p, lp_n}
  typedef logic [1:0] lp_code_t;
  localparam lp_code_t LP11 = 2'b11;
  localparam lp_code_t LP01 = 2'b01;
  localparam lp_code_t LP00 = 2'b00;

  function automatic logic is_hs_state(input state_t s);
    return (s == ST_HS_ZERO) || (s == ST_SYNC) || (s == ST_DATA) || (s == ST_TRAIL);
  endfunction

  function automatic logic is_clk_state(input state_t s);
    return is_hs_state(s) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/d_phy_serializer.sv
// 8-bit LSB-first shift register with bit index and 8th-bit strobe.
module d_phy_serializer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] load_data,
  output logic       bit_now,
  output logic       bit_next,
  output logic       last_bit,
  output logic       last_next
);

  logic [7:0] sh_q, sh_d;
  logic [2:0] idx_q, idx_d;

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (load) begin
      sh_d  = load_data;
      idx_d = '0;
    end else if (shift) begin
      sh_d  = {1'b0, sh_q[7:1]};
      idx_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  // next-cycle views let the top register its outputs without a bit of lag
  assign bit_now   = sh_q[0];
  assign bit_next  = sh_d[0];
  assign last_bit  = (idx_q == 3'd7);
  assign last_next = (idx_d == 3'd7);

endmodule

// File: rtl/d_phy_transmitter.sv
// Single-lane D-PHY HS transmitter: LP entry, HS-zero, sync, LSB-first data, trail, clock post.
module d_phy_transmitter
  import d_phy_pkg::*;
#(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 2,
  parameter int T_HS_ZERO    = 2,
  parameter int T_HS_TRAIL   = 8,
  parameter int T_CLK_POST   = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       hs_enable,
  output logic       hs_bit,
  output logic       lp_p,
  output logic       lp_n,
  output logic       clock_lane,
  output logic       busy
);

  localparam int LP00_LEN = T_LPX + T_HS_PREPARE;
  localparam int ZERO_LEN = 8 * T_HS_ZERO;
  localparam int MAX_A    = (LP00_LEN > ZERO_LEN) ? LP00_LEN : ZERO_LEN;
  localparam int MAX_B    = (T_HS_TRAIL > T_CLK_POST) ? T_HS_TRAIL : T_CLK_POST;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DWELL_W  = $clog2(T_LPX + 1);

  localparam logic [CNT_W-1:0]   LP01_LAST  = CNT_W'(T_LPX - 1);
  localparam logic [CNT_W-1:0]   LP00_LAST  = CNT_W'(LP00_LEN - 1);
  localparam logic [CNT_W-1:0]   ZERO_LAST  = CNT_W'(ZERO_LEN - 1);
  localparam logic [CNT_W-1:0]   TRAIL_LAST = CNT_W'(T_HS_TRAIL - 1);
  localparam logic [CNT_W-1:0]   POST_LAST  = CNT_W'((T_CLK_POST > 0) ? T_CLK_POST - 1 : 0);
  localparam logic [DWELL_W-1:0] DWELL_SAT  = DWELL_W'(T_LPX);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 hs_enable_q, hs_enable_d;
  logic                 hs_bit_q, hs_bit_d;
  lp_code_t             lp_q, lp_d;
  logic                 clock_lane_q, clock_lane_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic       ser_load, ser_shift;
  logic [7:0] ser_data;
  logic       ser_bit_now, ser_bit_next, ser_last_bit, ser_last_next;

  d_phy_serializer u_ser (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (ser_data),
    .bit_now   (ser_bit_now),
    .bit_next  (ser_bit_next),
    .last_bit  (ser_last_bit),
    .last_next (ser_last_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    dwell_d   = dwell_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_data  = data;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (dwell_q != DWELL_SAT) dwell_d = dwell_q + DWELL_W'(1);
        if (valid && (dwell_q == DWELL_SAT)) state_d = ST_LP01;
      end
      ST_LP01: if (cnt_q == LP01_LAST) begin
        state_d = ST_LP00;
        cnt_d   = '0;
      end
      ST_LP00: if (cnt_q == LP00_LAST) begin
        state_d = ST_HS_ZERO;
        cnt_d   = '0;
      end
      ST_HS_ZERO: if (cnt_q == ZERO_LAST) begin
        state_d  = ST_SYNC;
        cnt_d    = '0;
        ser_load = 1'b1;
        ser_data = SYNC_BYTE;
      end
      ST_SYNC: begin
        cnt_d     = '0;
        ser_shift = 1'b1;
        if (ser_last_bit) begin
          state_d  = ST_DATA;
          ser_load = 1'b1;
        end
      end
      ST_DATA: begin
        cnt_d     = '0;
        ser_shift = 1'b1;
        if (ser_last_bit) begin
          if (valid) ser_load = 1'b1;
          else       state_d  = ST_TRAIL;
        end
      end
      ST_TRAIL: if (cnt_q == TRAIL_LAST) begin
        cnt_d = '0;
        if (T_CLK_POST == 0) begin
          state_d = ST_IDLE;
          dwell_d = '0;
        end else begin
          state_d = ST_POST;
        end
      end
      ST_POST: if (cnt_q == POST_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dwell_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so each registered value lines up with state_q.
  always_comb begin
    hs_enable_d  = is_hs_state(state_d);
    busy_d       = (state_d != ST_IDLE);
    clock_lane_d = is_clk_state(state_d) ? ~clock_lane_q : 1'b0;
    ready_d      = ((state_d == ST_SYNC) || (state_d == ST_DATA)) && ser_last_next;
    case (state_d)
      ST_IDLE, ST_POST: lp_d = LP11;
      ST_LP01:          lp_d = LP01;
      default:          lp_d = LP00;
    endcase
    hs_bit_d = 1'b0;
    if ((state_d == ST_SYNC) || (state_d == ST_DATA)) begin
      hs_bit_d = ser_bit_next;
    end else if (state_d == ST_TRAIL) begin
      hs_bit_d = (state_q == ST_TRAIL) ? hs_bit_q : ~ser_bit_now;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      dwell_q      <= DWELL_SAT;
      hs_enable_q  <= 1'b0;
      hs_bit_q     <= 1'b0;
      lp_q         <= LP11;
      clock_lane_q <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dwell_q      <= dwell_d;
      hs_enable_q  <= hs_enable_d;
      hs_bit_q     <= hs_bit_d;
      lp_q         <= lp_d;
      clock_lane_q <= clock_lane_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
    end
  end

  assign ready      = ready_q;
  assign hs_enable  = hs_enable_q;
  assign hs_bit     = hs_bit_q;
  assign lp_p       = lp_q[1];
  assign lp_n       = lp_q[0];
  assign clock_lane = clock_lane_q;
  assign busy       = busy_q;

endmodule
